div_sequencer: RTL and testbench
================================

# div_sequencer

Iterative 32-bit divider with its own sequencing FSM for the DIV/DIVU path of the execute stage. It accepts one divide request from the EX stage and computes the quotient and remainder one bit per cycle using restoring division. While it runs it holds the pipeline through a stall output. It presents the results for write-back into HI/LO and can be cancelled by a pipeline flush.

## Interface
- WIDTH, 32, operand/result width; counter width is clog2(WIDTH).
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  divide request from EX; held high by the pipeline while stalled.
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start.
- dividend  in  WIDTH  rs operand; sampled with start.
- divisor  in  WIDTH  rt operand; sampled with start.
- annul  in  1  flush of the requesting instruction (exception/eret).
- stall  out  1  pipeline hold request.
- done  out  1  one-cycle pulse: quotient/remainder valid.
- quotient  out  WIDTH  to LO.
- remainder  out  WIDTH  to HI.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Reset:** state=IDLE, counter=0, quotient=0, remainder=0; stall=0, done=0.
- **IDLE:**
  - start=1 and annul=0 latches the operands.
  - If signed, the absolute value of each operand is latched, along with the quotient sign (signs differ) and the remainder sign (dividend sign).
  - divisor==0 goes directly to DONE. Otherwise go to BUSY with counter=0 and partial remainder=0.
- **BUSY:**
  - Each cycle, shift {rem,quo} left by 1 with the next dividend MSB entering.
  - Compute trial = rem − divisor as a WIDTH+1-bit subtract.
  - If trial is non-negative, rem=trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - After iteration WIDTH−1 (counter==WIDTH−1), go to DONE.
- **DONE** (one cycle):
  - Outputs carry sign-corrected results: quotient negated if the quotient sign is set, remainder negated if the remainder sign is set; two's complement, modulo 2^WIDTH.
  - Then go to IDLE unconditionally.
  - The start still held in this cycle is not re-accepted.
- **Divide by zero:** quotient=all ones, remainder=dividend (raw operand), for both signed and unsigned.
- **Overflow:** signed 0x80000000 / −1 gives quotient=0x80000000, remainder=0. This falls out of the modulo arithmetic; no trap.
- **quotient/remainder:** registered. Updated only on entry to DONE and held until the next DONE; unchanged by annul and by IDLE.
- **stall:** combinational, = (state==IDLE & start & ~annul) | (state==BUSY & ~annul). It is 0 in DONE so the pipeline advances in that cycle.
- **done:** = (state==DONE) & ~annul.
- **annul:**
  - In BUSY, go to IDLE on the next edge. No DONE, outputs unchanged.
  - In IDLE it blocks acceptance.
  - In DONE it suppresses done but does not block the output update.
- **start in BUSY/DONE:** ignored (no re-latching of operands).
- **Async reset mid-operation:** immediate return to reset values; no done.

## Timing
- start accepted at edge T (IDLE).
- BUSY during cycles T+1 … T+WIDTH, i.e. 32 cycles.
- DONE during cycle T+33: done=1, results valid, stall=0.
- IDLE from T+34.
- stall is high during cycles T … T+32, i.e. 33 cycles.
- Divide by zero: DONE in cycle T+1; stall is high in cycle T only.
- Back-to-back: the earliest next acceptance is at T+34.
- Annul at cycle A in BUSY: stall=0 in cycle A, IDLE at A+1; a new start can be accepted at A+1.

## Test plan
1. **Unsigned divide.** DIVU 100/7 at T → stall high for 33 cycles, done at T+33, quotient=14, remainder=2, then IDLE.
2. **Signed negative dividend.** DIV 0xFFFFFFF9 (−7) / 2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). DIVU with the same operands → quotient=0x7FFFFFFC, remainder=1.
3. **Signed overflow.** DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, done at T+33.
4. **Divide by zero.** DIVU 5/0 → done in cycle T+1, quotient=0xFFFFFFFF, remainder=5, stall high for exactly one cycle.
5. **Annul, then new request.**
   - annul at T+10 during BUSY → stall=0 that cycle, no done pulse, prior outputs retained.
   - New start at T+11 with DIV 7/7 → done 33 cycles later, quotient=1, remainder=0.
6. **Reset mid-operation.** resetn pulsed low at T+20 → stall=0, done=0, quotient=0, remainder=0 immediately. start held high after release → a fresh 33-cycle operation with correct results.

Source files
------------

// File: rtl/div_sequencer.sv
// Iterative restoring divider for DIV/DIVU. It produces one quotient bit per cycle and
// holds the pipeline through stall until results are ready for HI/LO write-back.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic             q_neg, r_neg;
  logic             accept, last, div0;
  logic [WIDTH-1:0] a_abs, b_abs, quo_nxt, rem_nxt;
  logic [WIDTH:0]   rem_sh, trial;

  assign accept = (state == IDLE) & start & ~annul;
  assign last   = (cnt == CW'(WIDTH-1));
  assign div0   = (divisor == '0);
  assign a_abs  = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_abs  = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;

  // quo doubles as the dividend shifter: its MSB feeds the partial remainder each step
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs};
  assign rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) begin
        stall     = 1'b1;
        state_nxt = div0 ? DONE : BUSY;
      end
      BUSY: if (annul) state_nxt = IDLE;
            else begin
              stall = 1'b1;
              if (last) state_nxt = DONE;
            end
      DONE: begin
        done      = ~annul;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // a held start must not hold the pipeline while the block sits in reset
    if (!resetn) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          quo   <= a_abs;
          dvs   <= b_abs;
          rem   <= '0;
          cnt   <= '0;
          q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg <= is_signed & dividend[WIDTH-1];
          if (div0) begin
            quotient  <= '1;
            remainder <= dividend;
          end
        end
        BUSY: if (!annul) begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            quotient  <= q_neg ? -quo_nxt : quo_nxt;
            remainder <= r_neg ? -rem_nxt : rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed divides push expected results, and a
// monitor compares them whenever done pulses.
module tb_div_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0, resetn = 1'b0, start = 1'b0, is_signed = 1'b0, annul = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         stall, done;
  logic [W-1:0] quotient, remainder;

  int             n_vec = 0, n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   last_q = '0, last_r = '0;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .annul(annul),
    .stall(stall), .done(done), .quotient(quotient), .remainder(remainder)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (resetn && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done=1 with nothing pending, q=%h r=%h", quotient, remainder);
      end else begin
        e = exp_q.pop_front();
        check("quotient", quotient, e[2*W-1:W]);
        check("remainder", remainder, e[W-1:0]);
      end
    end
  end

  // Called just after a rising edge; that cycle is T.
  task automatic run_op(input string name, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input int lat);
    int stalls = 0, seen = -1;
    exp_q.push_back({q, r});
    start = 1'b1; is_signed = sg; dividend = a; divisor = b;
    for (int k = 0; k < 40 && seen < 0; k++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) seen = k;
      else begin
        @(posedge clk); #1;
        // operands may change once sampled; the DUT must not re-latch them
        dividend = a ^ 32'h5A5A_5A5A;
        divisor  = b ^ 32'h00FF_00FF;
      end
    end
    if (seen < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no done within 40 cycles, want latency %0d", name, lat);
      exp_q.delete();
    end else check({name, "_latency"}, W'(seen), W'(lat));
    check({name, "_stall_cycles"}, W'(stalls), W'(lat));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({name, "_no_reaccept"}, {31'b0, stall}, '0);
    last_q = q;
    last_r = r;
  endtask

  initial begin
    #2;
    check("rst_stall", {31'b0, stall}, '0);
    check("rst_done", {31'b0, done}, '0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    @(posedge clk); #1 resetn = 1'b1;

    @(posedge clk); #1; run_op("divu_100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33);
    @(posedge clk); #1; run_op("div_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  33);
    @(posedge clk); #1; run_op("divu_m7_2",   1'b0, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  32'd1,         33);
    @(posedge clk); #1; run_op("div_ovf",     1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         33);
    @(posedge clk); #1; run_op("divu_5_0",    1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1);
    @(posedge clk); #1; run_op("div_m5_0",    1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1);
    @(posedge clk); #1; run_op("div_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         33);
    @(posedge clk); #1; run_op("div_m8_m3",   1'b1, 32'hFFFFFFF8,  32'hFFFFFFFD,  32'd2,         32'hFFFFFFFE,  33);
    @(posedge clk); #1; run_op("divu_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         33);

    // annul in IDLE blocks acceptance
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    check("idle_annul_stall", {31'b0, stall}, '0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    check("idle_annul_not_busy", {31'b0, stall}, '0);

    // annul during BUSY, then a new request the very next cycle
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    annul = 1'b1;
    @(negedge clk);
    check("busy_annul_stall", {31'b0, stall}, '0);
    check("busy_annul_done", {31'b0, done}, '0);
    check("busy_annul_keep_q", quotient, last_q);
    check("busy_annul_keep_r", remainder, last_r);
    @(posedge clk); #1;
    annul = 1'b0;
    run_op("div_7_7", 1'b1, 32'd7, 32'd7, 32'd1, 32'd0, 33);

    // asynchronous reset mid-operation, start held across release
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    repeat (20) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    check("midrst_stall", {31'b0, stall}, '0);
    check("midrst_done", {31'b0, done}, '0);
    check("midrst_quotient", quotient, '0);
    check("midrst_remainder", remainder, '0);
    @(posedge clk); #1;
    resetn = 1'b1;
    run_op("divu_1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
